// File: rtl/bit_density_modulator_if.sv
// Level-request handshake for bit_density_modulator: a valid/ready pair carrying
// one unsigned WIDTH-bit level per transfer.
interface bit_density_modulator_if #(
    parameter int WIDTH = 8
);
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] inData;

    modport master (output inValid, output inData, input inReady);
    modport slave  (input inValid, input inData, output inReady);
endinterface

// File: rtl/bit_density_modulator.sv
// First-order delta-sigma single-bit generator with a one-entry staging register.
// Optional build macro BIT_DENSITY_MODULATOR_DITHER_EN adds LFSR first-difference dither.
module bit_density_modulator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    bit_density_modulator_if.slave        in_if,
    output logic [WIDTH-1:0]              level,
    output logic                          bitOut
);

    logic [WIDTH-1:0] pend;
    logic             pendFull;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] eff;
    logic             accept;
    logic [WIDTH:0]   nxt_p0;

`ifdef BIT_DENSITY_MODULATOR_DITHER_EN
    // Returns {carry, new accumulator}; sum is never negative because t is
    // forced to zero whenever eff is zero.
    function automatic logic [WIDTH:0] dither_step(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] e,
                                                   input logic signed [1:0] t);
        logic signed [WIDTH+1:0] s;
        s = $signed({2'b00, a}) + $signed({2'b00, e}) + $signed({{WIDTH{t[1]}}, t});
        return {s[WIDTH] & ~s[WIDTH+1], s[WIDTH-1:0]};
    endfunction
`else
    function automatic logic [WIDTH:0] plain_step(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] e);
        return {1'b0, a} + {1'b0, e};
    endfunction
`endif

    assign in_if.inReady = ~pendFull & ~rst;
    assign accept        = in_if.inValid & in_if.inReady;
    // A staged value is applied on the very tick that transfers it.
    assign eff           = pendFull ? pend : level;

`ifdef BIT_DENSITY_MODULATOR_DITHER_EN
    logic [15:0]       lfsr;
    logic              dprev;
    logic              lfsr_fb;
    logic signed [1:0] dt;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign dt      = (eff == '0) ? 2'sd0
                                 : ($signed({1'b0, lfsr[0]}) - $signed({1'b0, dprev}));
    assign nxt_p0  = dither_step(acc, eff, dt);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr  <= 16'hACE1;
            dprev <= 1'b0;
        end else if (en) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            if (eff != '0) dprev <= lfsr[0];
        end
    end
`else
    assign nxt_p0 = plain_step(acc, eff);
`endif

    // Stage p0 -> registered outputs: staging, transfer and accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= '0;
            pendFull <= 1'b0;
            level    <= '0;
            acc      <= '0;
            bitOut   <= 1'b0;
        end else begin
            if (accept) begin
                pend     <= in_if.inData;
                pendFull <= 1'b1;
            end
            if (en) begin
                if (pendFull) begin
                    level    <= pend;
                    pendFull <= 1'b0;
                end
                acc    <= nxt_p0[WIDTH-1:0];
                bitOut <= nxt_p0[WIDTH];
            end
        end
    end

endmodule
